// File: rtl/spi_reg_access_sequencer.sv
// Mode-0 SPI frame sequencer: command byte {rw, addr} followed by register
// write/read data bytes, driving an external register bank in the SPI clock domain.
module spi_reg_access_sequencer #(
   parameter bit          AUTO_INC = 1'b1,
   parameter int unsigned ADDR_MAX = 127
) (
   input  logic       i_SPI_CLK,
   input  logic       i_rst,
   input  logic       i_SPI_CS_n,
   input  logic       i_SPI_PICO,
   output logic       o_POCI,
   output logic       o_POCI_oe,
   output logic       o_wrEn,
   output logic [6:0] o_wrAddr,
   output logic [7:0] o_wrData,
   output logic [6:0] o_rdAddr,
   input  logic [7:0] i_rdData,
   output logic       o_rdEn,
   output logic       o_frameAct
);

   localparam int unsigned AW = 7;
   localparam int unsigned DW = 8;
   localparam int unsigned CW = 3;

   typedef enum logic {ST_CMD, ST_DATA} state_t;

   state_t          state, nxt_state;
   logic [CW-1:0]   bit_cnt, nxt_bit_cnt;
   logic [DW-2:0]   shift, nxt_shift;
   logic            rw, nxt_rw;
   logic [AW-1:0]   addr, nxt_addr;
   logic [DW-1:0]   tx_byte, nxt_tx;
   logic            wr_en, nxt_wr_en;
   logic [AW-1:0]   wr_addr, nxt_wr_addr;
   logic [DW-1:0]   wr_data, nxt_wr_data;
   logic            rd_en, nxt_rd_en;
   logic            frame_act, nxt_frame_act;
   logic            poci;

   logic            clr;
   logic            byte_done;
   logic [DW-1:0]   rx_byte;
   logic [AW-1:0]   addr_inc;

   // Chip-select high ends the frame asynchronously, same as reset
   assign clr       = i_rst | i_SPI_CS_n;
   assign byte_done = (bit_cnt == CW'(7));
   assign rx_byte   = {shift, i_SPI_PICO};
   assign addr_inc  = (addr >= AW'(ADDR_MAX)) ? '0 : addr + AW'(1);

   // Read address looks ahead so the bank's data is ready on the byte-complete edge
   always_comb begin
      o_rdAddr = addr;
      if (byte_done) begin
         if (state == ST_CMD) begin
            o_rdAddr = {shift[5:0], i_SPI_PICO};
         end else if (AUTO_INC) begin
            o_rdAddr = addr_inc;
         end
      end
   end

   always_ff @(posedge i_SPI_CLK or posedge clr) begin
      if (clr) begin
         state     <= ST_CMD;
         bit_cnt   <= '0;
         shift     <= '0;
         rw        <= 1'b0;
         addr      <= '0;
         tx_byte   <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         rd_en     <= 1'b0;
         frame_act <= 1'b0;
      end else begin
         state     <= nxt_state;
         bit_cnt   <= nxt_bit_cnt;
         shift     <= nxt_shift;
         rw        <= nxt_rw;
         addr      <= nxt_addr;
         tx_byte   <= nxt_tx;
         wr_en     <= nxt_wr_en;
         wr_addr   <= nxt_wr_addr;
         wr_data   <= nxt_wr_data;
         rd_en     <= nxt_rd_en;
         frame_act <= nxt_frame_act;
      end
   end

   always_comb begin
      nxt_state     = state;
      nxt_bit_cnt   = bit_cnt + CW'(1);
      nxt_shift     = {shift[5:0], i_SPI_PICO};
      nxt_rw        = rw;
      nxt_addr      = addr;
      nxt_tx        = tx_byte;
      nxt_wr_en     = 1'b0;
      nxt_wr_addr   = wr_addr;
      nxt_wr_data   = wr_data;
      nxt_rd_en     = 1'b0;
      nxt_frame_act = frame_act;
      if (byte_done) begin
         case (state)
            ST_CMD: begin
               nxt_state     = ST_DATA;
               nxt_rw        = rx_byte[7];
               nxt_addr      = rx_byte[6:0];
               nxt_frame_act = 1'b1;
               if (rx_byte[7]) begin
                  nxt_tx    = i_rdData;
                  nxt_rd_en = 1'b1;
               end
            end
            ST_DATA: begin
               if (rw) begin
                  nxt_tx    = i_rdData;
                  nxt_rd_en = 1'b1;
               end else begin
                  nxt_wr_en   = 1'b1;
                  nxt_wr_addr = addr;
                  nxt_wr_data = rx_byte;
               end
               nxt_addr = AUTO_INC ? addr_inc : addr;
            end
            default: nxt_state = ST_CMD;
         endcase
      end
   end

   // Falling-edge shift out; bit_cnt has already advanced, so bit 7 follows the load edge
   always_ff @(negedge i_SPI_CLK or posedge clr) begin
      if (clr) begin
         poci <= 1'b0;
      end else begin
         poci <= (state == ST_DATA && rw) ? tx_byte[~bit_cnt] : 1'b0;
      end
   end

   assign o_POCI     = poci;
   assign o_POCI_oe  = ~i_SPI_CS_n;
   assign o_wrEn     = wr_en;
   assign o_wrAddr   = wr_addr;
   assign o_wrData   = wr_data;
   assign o_rdEn     = rd_en;
   assign o_frameAct = frame_act;

endmodule

// File: tb/tb_spi_reg_access_sequencer.sv
// Bench for spi_reg_access_sequencer: three parameterisations driven by one SPI
// controller, checked against a frame-level register-access model.
module tb_spi_reg_access_sequencer;

   logic       sclk, rst, cs_n, pico;
   logic [2:0] poci_v, oe_v, wr_en_v, rd_en_v, fa_v;
   logic [6:0] wr_addr_v [3];
   logic [6:0] rd_addr_v [3];
   logic [7:0] wr_data_v [3];
   logic [7:0] rd_data_v [3];
   logic [7:0] bank [128];

   int checks = 0;
   int errors = 0;

   // Per-DUT capture
   logic [14:0] wlog [3][64];
   int          wcnt [3];
   int          rdc  [3];
   logic [7:0]  rx   [3][16];

   // Stimulus and model expectations
   logic [7:0]  tx_buf [16];
   logic [14:0] exp_w [64];
   int          exp_wn;
   logic [7:0]  exp_r [16];
   int          exp_rdc;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      spi_reg_access_sequencer #(
         .AUTO_INC(g != 2),
         .ADDR_MAX((g == 1) ? 3 : 127)
      ) dut (
         .i_SPI_CLK (sclk),
         .i_rst     (rst),
         .i_SPI_CS_n(cs_n),
         .i_SPI_PICO(pico),
         .o_POCI    (poci_v[g]),
         .o_POCI_oe (oe_v[g]),
         .o_wrEn    (wr_en_v[g]),
         .o_wrAddr  (wr_addr_v[g]),
         .o_wrData  (wr_data_v[g]),
         .o_rdAddr  (rd_addr_v[g]),
         .i_rdData  (rd_data_v[g]),
         .o_rdEn    (rd_en_v[g]),
         .o_frameAct(fa_v[g])
      );
      assign rd_data_v[g] = bank[rd_addr_v[g]];
   end

   function automatic bit p_inc(int k);
      return k != 2;
   endfunction

   function automatic int p_max(int k);
      return (k == 1) ? 3 : 127;
   endfunction

   // Log strobes shortly after each rising edge
   always @(posedge sclk) begin
      #1;
      for (int k = 0; k < 3; k++) begin
         if (wr_en_v[k] === 1'b1 && wcnt[k] < 64) begin
            wlog[k][wcnt[k]] = {wr_addr_v[k], wr_data_v[k]};
            wcnt[k]++;
         end
         if (rd_en_v[k] === 1'b1) rdc[k]++;
      end
   end

   task automatic clear_capture();
      for (int k = 0; k < 3; k++) begin
         wcnt[k] = 0;
         rdc[k]  = 0;
         for (int j = 0; j < 16; j++) rx[k][j] = 8'h00;
      end
   endtask

   // Clock out nb bits of tx (MSB first), sampling POCI just before each rising edge
   task automatic spi_bits(input logic [7:0] tx, input int nb, input int idx);
      for (int i = 7; i > 7 - nb; i--) begin
         pico = tx[i];
         #4;
         for (int k = 0; k < 3; k++) rx[k][idx][i] = poci_v[k];
         #1 sclk = 1'b1;
         #5 sclk = 1'b0;
      end
   endtask

   // Frame-level reference: what a register-access frame should do to the bank port
   task automatic model(input int k, input int n);
      logic [6:0] a;
      logic       rw;
      a       = tx_buf[0][6:0];
      rw      = tx_buf[0][7];
      exp_wn  = 0;
      exp_rdc = rw ? n : 0;
      for (int j = 0; j < 16; j++) exp_r[j] = 8'h00;
      for (int j = 1; j < n; j++) begin
         if (rw) exp_r[j] = bank[a];
         else begin
            exp_w[exp_wn] = {a, tx_buf[j]};
            exp_wn++;
         end
         if (p_inc(k)) a = (int'(a) >= p_max(k)) ? 7'd0 : a + 7'd1;
      end
   endtask

   // Run one full frame of n bytes from tx_buf and compare every DUT with the model
   task automatic test_frame(input string name, input int n);
      clear_capture();
      cs_n = 1'b0;
      #5;
      checks++;
      if (oe_v !== 3'b111) begin
         errors++;
         $display("FAIL %s oe: got %b want 111", name, oe_v);
      end
      for (int b = 0; b < n; b++) begin
         spi_bits(tx_buf[b], 8, b);
         if (b == 0) begin
            checks++;
            if (fa_v !== 3'b111) begin
               errors++;
               $display("FAIL %s frame_act: got %b want 111", name, fa_v);
            end
         end
      end
      #5 cs_n = 1'b1;
      #10;
      for (int k = 0; k < 3; k++) begin
         model(k, n);
         checks++;
         if (wcnt[k] !== exp_wn) begin
            errors++;
            $display("FAIL %s dut%0d wr_count: got %0d want %0d", name, k, wcnt[k], exp_wn);
         end
         for (int i = 0; i < exp_wn && i < wcnt[k]; i++) begin
            checks++;
            if (wlog[k][i] !== exp_w[i]) begin
               errors++;
               $display("FAIL %s dut%0d write%0d: got addr %h data %h want addr %h data %h",
                        name, k, i, wlog[k][i][14:8], wlog[k][i][7:0], exp_w[i][14:8], exp_w[i][7:0]);
            end
         end
         checks++;
         if (rdc[k] !== exp_rdc) begin
            errors++;
            $display("FAIL %s dut%0d rd_en_count: got %0d want %0d", name, k, rdc[k], exp_rdc);
         end
         for (int j = 0; j < n; j++) begin
            checks++;
            if (rx[k][j] !== exp_r[j]) begin
               errors++;
               $display("FAIL %s dut%0d poci_byte%0d: got %h want %h", name, k, j, rx[k][j], exp_r[j]);
            end
         end
      end
      checks++;
      if (oe_v !== 3'b000 || fa_v !== 3'b000) begin
         errors++;
         $display("FAIL %s after_cs: oe %b frame_act %b want 000", name, oe_v, fa_v);
      end
   endtask

   task automatic test_reset();
      #10;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({poci_v[k], oe_v[k], wr_en_v[k], rd_en_v[k], fa_v[k], wr_addr_v[k], wr_data_v[k], rd_addr_v[k]} !== 27'd0) begin
            errors++;
            $display("FAIL reset dut%0d: poci %b oe %b wr %b rd %b fa %b wa %h wd %h ra %h want all 0",
                     k, poci_v[k], oe_v[k], wr_en_v[k], rd_en_v[k], fa_v[k], wr_addr_v[k], wr_data_v[k], rd_addr_v[k]);
         end
      end
      rst = 1'b0;
      #10;
   endtask

   task automatic test_write_frame();
      tx_buf[0] = 8'h05; tx_buf[1] = 8'hA5; tx_buf[2] = 8'h3C;
      test_frame("write", 3);
      checks++;
      if (wcnt[0] !== 2 || wlog[0][0] !== {7'd5, 8'hA5} || wlog[0][1] !== {7'd6, 8'h3C} || rdc[0] !== 0) begin
         errors++;
         $display("FAIL write_const: got n=%0d %h %h rd=%0d want n=2 05a5 063c rd=0",
                  wcnt[0], wlog[0][0], wlog[0][1], rdc[0]);
      end
   endtask

   task automatic test_read_frame();
      bank[7'h10] = 8'h81; bank[7'h11] = 8'h7E;
      tx_buf[0] = 8'h90; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
      test_frame("read", 3);
      checks++;
      if (rx[0][1] !== 8'h81 || rx[0][2] !== 8'h7E) begin
         errors++;
         $display("FAIL read_const: got %h %h want 81 7e", rx[0][1], rx[0][2]);
      end
   endtask

   task automatic test_wrap();
      tx_buf[0] = 8'h03; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22;
      test_frame("wrap", 3);
      checks++;
      if (wcnt[1] !== 2 || wlog[1][0] !== {7'd3, 8'h11} || wlog[1][1] !== {7'd0, 8'h22}) begin
         errors++;
         $display("FAIL wrap_const: got n=%0d %h %h want n=2 0311 0022", wcnt[1], wlog[1][0], wlog[1][1]);
      end
   endtask

   task automatic test_no_inc();
      tx_buf[0] = 8'h07; tx_buf[1] = 8'h01; tx_buf[2] = 8'h02;
      test_frame("no_inc", 3);
      checks++;
      if (wcnt[2] !== 2 || wlog[2][0] !== {7'd7, 8'h01} || wlog[2][1] !== {7'd7, 8'h02}) begin
         errors++;
         $display("FAIL no_inc_const: got n=%0d %h %h want n=2 0701 0702", wcnt[2], wlog[2][0], wlog[2][1]);
      end
   endtask

   task automatic test_partial_byte();
      clear_capture();
      cs_n = 1'b0;
      #5;
      spi_bits(8'h20, 8, 0);
      spi_bits(8'hFF, 4, 1);
      #5 cs_n = 1'b1;
      #10;
      checks++;
      if (wcnt[0] !== 0 || wcnt[1] !== 0 || wcnt[2] !== 0) begin
         errors++;
         $display("FAIL partial_wr: got %0d %0d %0d writes want 0", wcnt[0], wcnt[1], wcnt[2]);
      end
      checks++;
      if (oe_v !== 3'b000 || fa_v !== 3'b000) begin
         errors++;
         $display("FAIL partial_idle: oe %b frame_act %b want 000", oe_v, fa_v);
      end
      tx_buf[0] = 8'h21; tx_buf[1] = 8'h5A;
      test_frame("after_partial", 2);
      checks++;
      if (wcnt[0] !== 1 || wlog[0][0] !== {7'h21, 8'h5A}) begin
         errors++;
         $display("FAIL after_partial_const: got n=%0d %h want n=1 215a", wcnt[0], wlog[0][0]);
      end
   endtask

   task automatic test_reset_mid_frame();
      bank[7'h12] = 8'hC3;
      clear_capture();
      cs_n = 1'b0;
      #5;
      spi_bits(8'h92, 8, 0);
      spi_bits(8'h00, 3, 1);
      rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({poci_v[k], wr_en_v[k], rd_en_v[k], fa_v[k], wr_addr_v[k], wr_data_v[k], rd_addr_v[k]} !== 26'd0) begin
            errors++;
            $display("FAIL rst_mid dut%0d: poci %b wr %b rd %b fa %b wa %h wd %h ra %h want all 0",
                     k, poci_v[k], wr_en_v[k], rd_en_v[k], fa_v[k], wr_addr_v[k], wr_data_v[k], rd_addr_v[k]);
         end
      end
      #5 rst = 1'b0;
      cs_n = 1'b1;
      #10;
      tx_buf[0] = 8'h91; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
      test_frame("after_rst", 3);
   endtask

   task automatic test_random();
      for (int t = 0; t < 25; t++) begin
         int n;
         n = 1 + int'($urandom_range(0, 5));
         tx_buf[0] = 8'($urandom);
         for (int j = 1; j < n; j++) tx_buf[j] = 8'($urandom);
         test_frame($sformatf("rand%0d", t), n);
      end
   endtask

   initial begin
      sclk = 1'b0;
      pico = 1'b0;
      cs_n = 1'b1;
      rst  = 1'b1;
      for (int i = 0; i < 128; i++) bank[i] = 8'($urandom);
      clear_capture();
      test_reset();
      test_write_frame();
      test_read_frame();
      test_wrap();
      test_no_inc();
      test_partial_byte();
      test_reset_mid_frame();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
